// File: rtl/usb_transmitter.sv
// Full-speed USB transmitter: SYNC, NRZI with bit stuffing and EOP onto D+/D-,
// fed from a one-byte holding register on a valid/ready byte stream.
module usb_transmitter #(
    parameter int CLOCKS_PER_BIT = 4
) (
    input  logic       clock48,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       usb_tx_d_p,
    output logic       usb_tx_d_n,
    output logic       usb_tx_oe,
    output logic       busy,
    output logic       underrun
);
    localparam int            PW         = (CLOCKS_PER_BIT > 1) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLOCKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
    localparam logic [PW-1:0] PHASE_ZERO = PW'(0);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        DATA    = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4
    } state_t;

    state_t        state, state_nx;
    logic [PW-1:0] phase, phase_nx, phase_adv;
    logic [2:0]    bit_cnt, bit_cnt_nx;
    logic [2:0]    stuff_cnt, stuff_cnt_nx;
    logic [7:0]    shifter, shifter_nx;
    logic [7:0]    hold_data, hold_data_nx;
    logic          hold_full, hold_full_nx;
    logic          hold_last, hold_last_nx;
    logic          shift_last, shift_last_nx;
    logic          closed, closed_nx;
    logic          d_p_nx, d_n_nx, oe_nx, busy_nx, underrun_nx;
    logic          accept, phase_end, emit, emit_bit, load;

    // closed marks a packet that can take no more bytes: its last byte was
    // accepted, or it was cut short by an underrun. Only IDLE reopens it.
    assign tx_ready  = !hold_full && !closed;
    assign accept    = tx_valid && tx_ready;
    assign phase_end = (phase == PHASE_LAST);
    assign phase_adv = phase_end ? PHASE_ZERO : (phase + PHASE_ONE);

    // Next-state logic: handshake, bit sequencing, stuffing and line symbol
    always_comb begin
        state_nx      = state;
        phase_nx      = phase_adv;
        bit_cnt_nx    = bit_cnt;
        stuff_cnt_nx  = stuff_cnt;
        shifter_nx    = shifter;
        hold_data_nx  = hold_data;
        hold_full_nx  = hold_full;
        hold_last_nx  = hold_last;
        shift_last_nx = shift_last;
        closed_nx     = closed;
        d_p_nx        = usb_tx_d_p;
        d_n_nx        = usb_tx_d_n;
        oe_nx         = usb_tx_oe;
        busy_nx       = busy;
        underrun_nx   = 1'b0;
        emit          = 1'b0;
        emit_bit      = 1'b0;
        load          = 1'b0;

        if (accept) begin
            hold_data_nx = tx_data;
            hold_full_nx = 1'b1;
            hold_last_nx = tx_last;
            closed_nx    = tx_last;
        end else begin
            hold_full_nx = hold_full;
        end

        case (state)
            IDLE: begin
                phase_nx = PHASE_ZERO;
                if (accept) begin
                    state_nx     = SYNC;
                    oe_nx        = 1'b1;
                    busy_nx      = 1'b1;
                    d_p_nx       = 1'b0;
                    d_n_nx       = 1'b1;
                    bit_cnt_nx   = 3'd0;
                    stuff_cnt_nx = 3'd0;
                end else begin
                    oe_nx   = 1'b0;
                    busy_nx = 1'b0;
                    d_p_nx  = 1'b1;
                    d_n_nx  = 1'b0;
                end
            end
            SYNC: begin
                if (phase_end && (bit_cnt == 3'd7)) begin
                    load = 1'b1;
                end else if (phase_end) begin
                    bit_cnt_nx = bit_cnt + 3'd1;
                    emit       = 1'b1;
                    emit_bit   = (bit_cnt == 3'd6);
                end else begin
                    bit_cnt_nx = bit_cnt;
                end
            end
            DATA: begin
                if (!phase_end) begin
                    bit_cnt_nx = bit_cnt;
                end else if (stuff_cnt == 3'd6) begin
                    d_p_nx       = ~usb_tx_d_p;
                    d_n_nx       = ~usb_tx_d_n;
                    stuff_cnt_nx = 3'd0;
                end else if (bit_cnt != 3'd0) begin
                    emit       = 1'b1;
                    emit_bit   = shifter[0];
                    shifter_nx = {1'b0, shifter[7:1]};
                    bit_cnt_nx = bit_cnt - 3'd1;
                end else if (!shift_last && hold_full) begin
                    load = 1'b1;
                end else begin
                    underrun_nx = !shift_last;
                    closed_nx   = 1'b1;
                    state_nx    = EOP_SE0;
                    d_p_nx      = 1'b0;
                    d_n_nx      = 1'b0;
                    bit_cnt_nx  = 3'd0;
                end
            end
            EOP_SE0: begin
                if (phase_end && (bit_cnt == 3'd1)) begin
                    state_nx = EOP_J;
                    d_p_nx   = 1'b1;
                    d_n_nx   = 1'b0;
                end else if (phase_end) begin
                    bit_cnt_nx = 3'd1;
                end else begin
                    bit_cnt_nx = bit_cnt;
                end
            end
            EOP_J: begin
                if (phase_end) begin
                    state_nx     = IDLE;
                    oe_nx        = 1'b0;
                    busy_nx      = 1'b0;
                    closed_nx    = 1'b0;
                    hold_full_nx = 1'b0;
                end else begin
                    state_nx = EOP_J;
                end
            end
            default: begin
                state_nx     = IDLE;
                phase_nx     = PHASE_ZERO;
                oe_nx        = 1'b0;
                busy_nx      = 1'b0;
                d_p_nx       = 1'b1;
                d_n_nx       = 1'b0;
                closed_nx    = 1'b0;
                hold_full_nx = 1'b0;
            end
        endcase

        if (load) begin
            emit          = 1'b1;
            emit_bit      = hold_data[0];
            shifter_nx    = {1'b0, hold_data[7:1]};
            bit_cnt_nx    = 3'd7;
            shift_last_nx = hold_last;
            hold_full_nx  = 1'b0;
            state_nx      = DATA;
        end else begin
            shift_last_nx = shift_last;
        end

        // NRZI: a 1 holds the line and extends the run, a 0 toggles it
        if (emit && emit_bit) begin
            stuff_cnt_nx = stuff_cnt + 3'd1;
        end else if (emit) begin
            stuff_cnt_nx = 3'd0;
            d_p_nx       = ~usb_tx_d_p;
            d_n_nx       = ~usb_tx_d_n;
        end else begin
            emit_bit = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clock48) begin
        if (!reset_n) begin
            state      <= IDLE;
            phase      <= PHASE_ZERO;
            bit_cnt    <= 3'd0;
            stuff_cnt  <= 3'd0;
            shifter    <= 8'd0;
            hold_data  <= 8'd0;
            hold_full  <= 1'b0;
            hold_last  <= 1'b0;
            shift_last <= 1'b0;
            closed     <= 1'b0;
            usb_tx_d_p <= 1'b1;
            usb_tx_d_n <= 1'b0;
            usb_tx_oe  <= 1'b0;
            busy       <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_nx;
            phase      <= phase_nx;
            bit_cnt    <= bit_cnt_nx;
            stuff_cnt  <= stuff_cnt_nx;
            shifter    <= shifter_nx;
            hold_data  <= hold_data_nx;
            hold_full  <= hold_full_nx;
            hold_last  <= hold_last_nx;
            shift_last <= shift_last_nx;
            closed     <= closed_nx;
            usb_tx_d_p <= d_p_nx;
            usb_tx_d_n <= d_n_nx;
            usb_tx_oe  <= oe_nx;
            busy       <= busy_nx;
            underrun   <= underrun_nx;
        end
    end
endmodule

// File: tb/tb_usb_transmitter.sv
// Scoreboard bench for usb_transmitter: hand-computed line symbol sequences are
// queued per packet and a negedge monitor compares every driven cycle.
module tb_usb_transmitter;
    logic       clock48  = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last  = 1'b0;
    logic       tx_ready, usb_tx_d_p, usb_tx_d_n, usb_tx_oe, busy, underrun;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    int         len_q[$];
    int         urun_q[$];
    logic       mon_en = 1'b0;

    localparam string SYNC_S = "KJKJKJKK";
    localparam string EOP_S  = "00J";

    always #5 clock48 = ~clock48;

    usb_transmitter #(.CLOCKS_PER_BIT(4)) dut (
        .clock48(clock48), .reset_n(reset_n), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .usb_tx_d_p(usb_tx_d_p), .usb_tx_d_n(usb_tx_d_n),
        .usb_tx_oe(usb_tx_oe), .busy(busy), .underrun(underrun)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=missing required=present", name);
    endtask

    // Symbols: K=01, J=10, 0=SE0; urun is the oe-cycle index of the underrun pulse or -1
    task automatic push_pkt(input string s, input int urun);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s.getc(i);
            if (c == "K") exp_q.push_back(2'b01);
            else if (c == "J") exp_q.push_back(2'b10);
            else exp_q.push_back(2'b00);
        end
        len_q.push_back(s.len() * 4);
        urun_q.push_back(urun);
    endtask

    // Monitor state
    logic [1:0] cur_sym;
    int         pcnt;
    int         urun_at;
    bit         in_pkt   = 1'b0;
    bit         prev_acc = 1'b0;

    always @(negedge clock48) begin
        if (!mon_en) begin
            in_pkt   = 1'b0;
            prev_acc = 1'b0;
        end else if (usb_tx_oe) begin
            if (!in_pkt) begin
                in_pkt  = 1'b1;
                pcnt    = 0;
                urun_at = -1;
                check("start_latency", int'(prev_acc), 1);
            end
            if (pcnt % 4 == 0) begin
                if (exp_q.size() == 0) begin
                    flag_fail("symbol_expectation");
                    cur_sym = 2'b11;
                end else begin
                    cur_sym = exp_q.pop_front();
                end
            end
            check($sformatf("line_cycle_%0d", pcnt), int'({usb_tx_d_p, usb_tx_d_n}), int'(cur_sym));
            check("busy_in_pkt", int'(busy), 1);
            if (underrun) urun_at = pcnt;
            pcnt++;
        end else begin
            if (in_pkt) begin
                in_pkt = 1'b0;
                if (len_q.size() == 0) flag_fail("length_expectation");
                else check("oe_cycles", pcnt, len_q.pop_front());
                if (urun_q.size() == 0) flag_fail("underrun_expectation");
                else check("underrun_cycle", urun_at, urun_q.pop_front());
            end
            check("idle_line_J", int'({usb_tx_d_p, usb_tx_d_n}), 2);
            check("idle_busy", int'(busy), 0);
            check("idle_underrun", int'(underrun), 0);
        end
        prev_acc = tx_valid && tx_ready;
    end

    // Must be called at posedge+#1; returns at posedge+#1 just after acceptance
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        tx_data  = d;
        tx_last  = l;
        tx_valid = 1'b1;
        @(negedge clock48);
        while (!tx_ready && n < 3000) begin
            @(negedge clock48);
            n++;
        end
        if (!tx_ready) flag_fail("accept_timeout");
        @(posedge clock48);
        #1;
    endtask

    task automatic wait_pkt_end();
        int n = 0;
        do begin
            @(negedge clock48);
            n++;
        end while (usb_tx_oe && n < 2000);
        if (usb_tx_oe) flag_fail("packet_end_timeout");
        @(posedge clock48);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_oe"}, int'(usb_tx_oe), 0);
        check({tag, "_line"}, int'({usb_tx_d_p, usb_tx_d_n}), 2);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_ready"}, int'(tx_ready), 1);
        check({tag, "_underrun"}, int'(underrun), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        logic prev_oe;

        repeat (3) @(posedge clock48);
        @(negedge clock48);
        check_reset_state("reset");
        @(posedge clock48); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(posedge clock48); #1;

        // Single byte 0xD2
        push_pkt({SYNC_S, "JJKJJKKK", EOP_S}, -1);
        send_byte(8'hD2, 1'b1);
        tx_valid = 1'b0;
        bad = 0;
        n = 0;
        forever begin
            @(negedge clock48);
            n++;
            if (!usb_tx_oe || n > 2000) break;
            if (tx_ready) bad++;
        end
        check("ready_low_in_pkt", bad, 0);
        check("ready_after_pkt", int'(tx_ready), 1);
        @(posedge clock48); #1;

        // 0xFF,0xFF: stuff bits after data bits 5 and 11
        push_pkt({SYNC_S, "KKKKKJJJJJJJKKKKKK", EOP_S}, -1);
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b1);
        check("byte2_accepted_mid_pkt", int'(usb_tx_oe), 1);
        tx_valid = 1'b0;
        wait_pkt_end();

        // 0xFC: trailing stuff bit before EOP
        push_pkt({SYNC_S, "JKKKKKKKJ", EOP_S}, -1);
        send_byte(8'hFC, 1'b1);
        tx_valid = 1'b0;
        wait_pkt_end();

        // Underrun after first byte
        push_pkt({SYNC_S, "JJKJJKKK", EOP_S}, 64);
        send_byte(8'hD2, 1'b0);
        tx_valid = 1'b0;
        wait_pkt_end();
        check("ready_after_underrun", int'(tx_ready), 1);

        // Reset during byte 2 of a 4-byte packet
        mon_en = 1'b0;
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        tx_valid = 1'b0;
        repeat (10) @(posedge clock48);
        #1;
        reset_n = 1'b0;
        @(posedge clock48); #1;
        reset_n = 1'b1;
        @(negedge clock48);
        check_reset_state("midpkt_reset");
        @(posedge clock48); #1;
        mon_en = 1'b1;
        @(posedge clock48); #1;

        push_pkt({SYNC_S, "JJKJJKKK", EOP_S}, -1);
        send_byte(8'hD2, 1'b1);
        tx_valid = 1'b0;
        wait_pkt_end();

        // Back-to-back packets
        push_pkt({SYNC_S, "JJKJJKKK", EOP_S}, -1);
        push_pkt({SYNC_S, "JJKJJKKK", EOP_S}, -1);
        send_byte(8'hD2, 1'b1);
        prev_oe = 1'b0;
        n = 0;
        forever begin
            @(negedge clock48);
            n++;
            if (tx_ready || n > 2000) break;
            prev_oe = usb_tx_oe;
        end
        check("b2b_oe_at_accept", int'(usb_tx_oe), 0);
        check("b2b_oe_before_accept", int'(prev_oe), 1);
        @(posedge clock48); #1;
        tx_valid = 1'b0;
        wait_pkt_end();

        repeat (4) @(posedge clock48);
        check("symbols_drained", exp_q.size(), 0);
        check("lengths_drained", len_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
